// File: rtl/pong_pixel_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pixel_gen_if
//  Purpose  : Pixel-side bundle between the VGA timing stage (master) and the
//             Pong pixel generator (slave).
//  Signals  : video_on, x[9:0], y[9:0], btn_up, btn_down   master -> slave
//             rgb[11:0], miss, hit_count[7:0]               slave  -> master
//  Revision : 1.0  initial release
// ============================================================================
interface pong_pixel_gen_if;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] rgb;
    logic        miss;
    logic [7:0]  hit_count;

    modport master (
        output video_on, x, y, btn_up, btn_down,
        input  rgb, miss, hit_count
    );

    modport slave (
        input  video_on, x, y, btn_up, btn_down,
        output rgb, miss, hit_count
    );
endinterface
`default_nettype wire

// File: rtl/pong_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pixel_gen
//  Purpose  : Pong object state (paddle, ball, serve/play/miss FSM) updated
//             once per frame, plus registered 12-bit RGB for the current
//             pixel (one cycle of latency).
//  Ports    : clk_25MHz  pixel clock
//             reset      synchronous, active-low (0 = reset)
//             bus        pong_pixel_gen_if.slave: video_on, x, y, btn_up,
//                        btn_down in; rgb, miss, hit_count out
//  Revision : 1.0  initial release
// ============================================================================
module pong_pixel_gen #(
    parameter int WALL_XL  = 32,
    parameter int WALL_XR  = 39,
    parameter int PAD_XL   = 600,
    parameter int PAD_XR   = 603,
    parameter int PAD_H    = 72,
    parameter int PAD_V    = 3,
    parameter int BALL_S   = 8,
    parameter int BALL_V   = 2,
    parameter int SERVE_FR = 60
) (
    input  logic               clk_25MHz,
    input  logic               reset,
    pong_pixel_gen_if.slave    bus
);

    // 11-bit working copies so no arithmetic wraps near row 0 or column 639
    localparam logic [10:0] c_wall_xl = 11'(WALL_XL);
    localparam logic [10:0] c_wall_xr = 11'(WALL_XR);
    localparam logic [10:0] c_pad_xl  = 11'(PAD_XL);
    localparam logic [10:0] c_pad_xr  = 11'(PAD_XR);
    localparam logic [10:0] c_pad_h   = 11'(PAD_H);
    localparam logic [10:0] c_pad_v   = 11'(PAD_V);
    localparam logic [10:0] c_ball_s  = 11'(BALL_S);
    localparam logic [10:0] c_ball_v  = 11'(BALL_V);
    localparam logic [10:0] c_rows    = 11'd480;
    localparam logic [10:0] c_col_max = 11'd639;
    localparam logic [10:0] c_pad_y0  = 11'd204;
    localparam logic [10:0] c_bx0     = 11'd320 - c_ball_s / 11'd2;
    localparam logic [10:0] c_by0     = 11'd240 - c_ball_s / 11'd2;
    localparam logic [7:0]  c_srv_end = 8'(SERVE_FR - 1);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] pad_y_q, pad_y_d;
    logic [10:0] bx_q, bx_d;
    logic [10:0] by_q, by_d;
    logic        dx_q, dx_d;            // 1 = moving right
    logic        dy_q, dy_d;            // 1 = moving down
    logic [7:0]  serve_cnt_q, serve_cnt_d;
    logic [7:0]  hit_count_q, hit_count_d;
    logic        miss_q, miss_d;
    logic [11:0] rgb_q, rgb_d;

    logic [10:0] w_x, w_y;
    logic        w_tick;
    logic        w_dx_play, w_dy_play, w_hit, w_exit;
    logic        w_wall, w_paddle, w_ball;

    assign w_x    = {1'b0, bus.x};
    assign w_y    = {1'b0, bus.y};
    assign w_tick = (bus.y == 10'd481) && (bus.x == 10'd0);

    // Direction updates from the floor/ceiling and left wall, evaluated on
    // the current ball position before it moves.
    assign w_dy_play = (by_q <= c_ball_v) ? 1'b1 :
                       ((by_q + c_ball_s >= c_rows - c_ball_v) ? 1'b0 : dy_q);
    assign w_dx_play = (bx_q <= c_wall_xr + c_ball_v + 11'd1) ? 1'b1 : dx_q;

    // Paddle catch window extends BALL_V past the paddle's right edge so a
    // ball stepping 2 px per frame cannot jump through the 4 px paddle.
    assign w_hit  = w_dx_play
                 && (bx_q + c_ball_s - 11'd1 >= c_pad_xl)
                 && (bx_q + c_ball_s - 11'd1 <= c_pad_xr + c_ball_v)
                 && (by_q + c_ball_s - 11'd1 >= pad_y_q)
                 && (by_q <= pad_y_q + c_pad_h - 11'd1);
    assign w_exit = (bx_q + c_ball_s - 11'd1 > c_col_max - c_ball_v);

    // Next-state logic: everything except rgb moves only on the frame tick
    always_comb begin
        state_d     = state_q;
        pad_y_d     = pad_y_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_cnt_d = serve_cnt_q;
        hit_count_d = hit_count_q;
        miss_d      = 1'b0;

        if (w_tick) begin
            if (bus.btn_up && !bus.btn_down) begin
                pad_y_d = (pad_y_q > c_pad_v) ? pad_y_q - c_pad_v : 11'd0;
            end else if (bus.btn_down && !bus.btn_up) begin
                pad_y_d = (pad_y_q + c_pad_h + c_pad_v <= c_rows) ?
                          pad_y_q + c_pad_v : c_rows - c_pad_h;
            end

            case (state_q)
                ST_SERVE: begin
                    bx_d = c_bx0;
                    by_d = c_by0;
                    if (serve_cnt_q == c_srv_end) begin
                        serve_cnt_d = 8'd0;
                        dx_d        = 1'b1;
                        dy_d        = 1'b1;
                        state_d     = ST_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 8'd1;
                    end
                end
                ST_PLAY: begin
                    dy_d = w_dy_play;
                    dx_d = w_hit ? 1'b0 : w_dx_play;
                    if (w_hit) begin
                        hit_count_d = hit_count_q + 8'd1;
                    end
                    if (!w_hit && w_exit) begin
                        state_d = ST_MISS;
                        miss_d  = 1'b1;
                    end else begin
                        bx_d = dx_d ? bx_q + c_ball_v : bx_q - c_ball_v;
                        by_d = dy_d ? by_q + c_ball_v : by_q - c_ball_v;
                    end
                end
                ST_MISS: begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = 8'd0;
                    bx_d        = c_bx0;
                    by_d        = c_by0;
                end
                default: begin
                    state_d = ST_SERVE;
                end
            endcase
        end
    end

    // Pixel classification and colour, priority wall > paddle > ball
    always_comb begin
        w_wall   = (w_x >= c_wall_xl) && (w_x <= c_wall_xr) && (w_y < c_rows);
        w_paddle = (w_x >= c_pad_xl) && (w_x <= c_pad_xr)
                && (w_y >= pad_y_q) && (w_y <= pad_y_q + c_pad_h - 11'd1);
        w_ball   = (state_q != ST_MISS)
                && (w_x >= bx_q) && (w_x <= bx_q + c_ball_s - 11'd1)
                && (w_y >= by_q) && (w_y <= by_q + c_ball_s - 11'd1);
        rgb_d    = 12'h000;
        if (bus.video_on) begin
            if (w_wall)        rgb_d = 12'h00F;
            else if (w_paddle) rgb_d = 12'h0F0;
            else if (w_ball)   rgb_d = 12'hF00;
            else               rgb_d = 12'h111;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!reset) begin
            state_q     <= ST_SERVE;
            pad_y_q     <= c_pad_y0;
            bx_q        <= c_bx0;
            by_q        <= c_by0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_cnt_q <= 8'd0;
            hit_count_q <= 8'd0;
            miss_q      <= 1'b0;
            rgb_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            pad_y_q     <= pad_y_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_cnt_q <= serve_cnt_d;
            hit_count_q <= hit_count_d;
            miss_q      <= miss_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.miss      = miss_q;
    assign bus.hit_count = hit_count_q;

endmodule
`default_nettype wire

// File: doc/pong_pixel_gen.md
Name: pong_pixel_gen

Overview:
- Downstream consumer of the VGA timing stage.
- Takes the current pixel coordinate (x, y) and video_on. Runs the Pong object state (paddle, ball, serve/miss FSM) once per frame, and produces registered 12-bit RGB for the DAC/pins.
- The top level delays hsync/vsync by one clock to match this block's 1-cycle RGB latency.

Parameters:
- WALL_XL, 32, left wall first column
- WALL_XR, 39, left wall last column
- PAD_XL, 600, paddle first column
- PAD_XR, 603, paddle last column
- PAD_H, 72, paddle height in rows
- PAD_V, 3, paddle step per frame
- BALL_S, 8, ball side in pixels
- BALL_V, 2, ball step per frame per axis
- SERVE_FR, 60, frames the ball is held at centre before launch

Ports:
- clk_25MHz  in  1  pixel clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- video_on  in  1  high inside the 640x480 display area
- x  in  10  current pixel column, 0-799
- y  in  10  current pixel row, 0-524
- btn_up  in  1  move paddle up, level-sensitive, pre-synchronised
- btn_down  in  1  move paddle down, level-sensitive, pre-synchronised
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}, registered
- miss  out  1  one-cycle pulse when the ball exits past the paddle
- hit_count  out  8  paddle hits since reset, wraps 255->0

Behaviour:
- Reset (reset==0 at a clk edge), all of these at once:
  - rgb=0, miss=0, hit_count=0
  - pad_y=204 (paddle top row)
  - ball (bx,by)=(316,236)
  - dx=right, dy=down
  - state=SERVE, serve_cnt=0
  - Reset mid-frame or mid-play restarts everything immediately.
- Frame tick:
  - tick = (y==481 && x==0), combinational; exactly one cycle per frame.
  - All object state changes only on tick, except rgb, which updates every cycle.
- Paddle, on tick:
  - btn_up only: pad_y <= (pad_y > PAD_V) ? pad_y-PAD_V : 0.
  - btn_down only: pad_y <= (pad_y+PAD_H+PAD_V <= 480) ? pad_y+PAD_V : 480-PAD_H.
  - Both or neither: hold.
  - The paddle moves in every state.
- FSM states: SERVE, PLAY, MISS.
- SERVE:
  - Ball forced to (316,236).
  - On each tick, serve_cnt increments.
  - On the tick where serve_cnt==SERVE_FR-1: serve_cnt<=0, dx=right, dy=down, go to PLAY.
- PLAY, on tick. Evaluate the checks below in order on current positions, then move the ball with the updated directions in the same tick:
  1. by <= BALL_V -> dy=down. Else by+BALL_S >= 480-BALL_V -> dy=up.
  2. bx <= WALL_XR+BALL_V+1 -> dx=right.
  3. Paddle hit, all three conditions true:
     - dx==right,
     - bx+BALL_S-1 is in [PAD_XL, PAD_XR+BALL_V],
     - by+BALL_S-1 >= pad_y and by <= pad_y+PAD_H-1.
     Result: dx=left and hit_count++.
  4. bx+BALL_S-1 > 639-BALL_V with no hit -> go to MISS, miss=1 for exactly that one cycle, ball not moved.
  5. Otherwise bx±=BALL_V and by±=BALL_V.
  - Corner case: a wall hit and a paddle hit on the same tick both apply.
- MISS:
  - Ball not drawn.
  - On the next tick: go to SERVE, serve_cnt=0.
- Pixel classification (on x,y):
  - wall = x in [WALL_XL, WALL_XR] and y < 480.
  - paddle = x in [PAD_XL, PAD_XR] and y in [pad_y, pad_y+PAD_H-1].
  - ball = state!=MISS and x in [bx, bx+BALL_S-1] and y in [by, by+BALL_S-1].
- rgb, registered every cycle:
  - video_on==0 -> 12'h000.
  - Otherwise, in priority order: wall -> 12'h00F, paddle -> 12'h0F0, ball -> 12'hF00, background -> 12'h111.
- Latency: rgb reflects the (x,y,video_on) presented one cycle earlier.
- Widths: all position arithmetic is 11-bit internally so no wrap occurs near 0 or 639.

Test Plan:
1. Drive x,y as a VGA scan (800x525) with reset=0 for 3 cycles, then release -> rgb=0 during reset; after release, rgb at (x=320,y=240)+1 cycle = 12'hF00 and at (35,100)+1 cycle = 12'h00F. Blanked pixels (x>=640) give 0.
2. Hold btn_up for 80 frames -> pad_y decrements by 3 per tick and stops at 0. Then hold btn_down for 200 frames -> pad_y saturates at 408. Both buttons held -> pad_y unchanged.
3. After reset, count ticks -> ball stays at (316,236) for 60 ticks, then moves to (318,238) on tick 61 (PLAY).
4. Hold pad_y so the ball's path intersects the paddle -> on the hit tick dx flips to left, hit_count goes 0->1, and the ball x decreases on the following ticks.
5. Park the paddle at 0 while the ball descends on the lower half -> miss pulses high for exactly 1 cycle. The ball is absent from rgb for one frame, then reappears at (316,236) in SERVE. hit_count is unchanged.
6. Assert reset mid-PLAY at x=100,y=200 -> next cycle all outputs are at reset values; play resumes after 60 serve frames.
